// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg
// Shared definitions for the branch predictor training slice:
//   - 2-bit saturating counter encodings (strongly/weakly not-taken/taken)
//   - sat_next(): the counter training rule applied when a branch resolves
// The in-flight queue entry layout depends on the history width, so the
// entry struct lives next to the HIST_BITS parameter in bpred_train.
// -----------------------------------------------------------------------------
package bpred_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Move the counter one step toward the actual outcome, clamping at the
  // strong states so a long run of one direction cannot wrap around.
  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken) begin
      if (ctr != ST) result = ctr + 2'd1;
    end else begin
      if (ctr != SNT) result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bpred_queue.sv
// -----------------------------------------------------------------------------
// bpred_queue
// Synchronous FIFO holding the in-flight predicted branches, oldest at head.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   push_i, data_i    append data_i at the tail
//   pop_i             drop the head entry
//   flush_i           empty the queue; wins over push_i and pop_i
//   head_o            oldest entry (meaningful only when empty_o is low)
//   count_o           number of valid entries, 0..DEPTH
//   full_o, empty_o   occupancy flags from registered state
// The owner never pushes while full nor pops while empty.
// -----------------------------------------------------------------------------
module bpred_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap on their own; the count is one bit wider to hold DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        wrPtr_d = wrPtr_q + PW'(1);
        count_d = count_d + CW'(1);
      end
      if (pop_i) begin
        rdPtr_d = rdPtr_q + PW'(1);
        count_d = count_d - CW'(1);
      end
    end
  end

  // State register plus storage write; a flushed push is wrong-path and is
  // not written.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push_i && !flush_i) mem_q[wrPtr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpred_train.sv
// -----------------------------------------------------------------------------
// bpred_train
// Training/history half of a two-level branch predictor. Owns the global
// history register (BHR) and the pattern table (BPT) of 2-bit counters,
// tracks predicted branches until execute resolves them, trains counters on
// resolve, and repairs history plus flushes younger branches on mispredict.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   lookup_valid      fetch requests a prediction for a conditional branch
//   lookup_ready      lookup is accepted this cycle (queue not full)
//   lookup_counter    BPT[BHR], combinational; bit 1 is the predicted direction
//   resolve_valid     execute resolves the oldest in-flight branch
//   resolve_taken     actual direction of that branch
//   mispredict        one-cycle pulse the cycle after a mispredicting resolve
//   pending_count     number of in-flight branches
// -----------------------------------------------------------------------------
module bpred_train
  import bpred_pkg::*;
#(
  parameter int HIST_BITS = 2,
  parameter int QDEPTH    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  output logic [1:0]                  lookup_counter,
  input  logic                        resolve_valid,
  input  logic                        resolve_taken,
  output logic                        mispredict,
  output logic [$clog2(QDEPTH+1)-1:0] pending_count
);

  localparam int ENTRIES = 1 << HIST_BITS;

  typedef struct packed {
    logic [HIST_BITS-1:0] hist;
    logic                 pred;
  } entry_t;

  logic [HIST_BITS-1:0] bhr_q, bhr_d;
  logic [1:0]           bpt_q [ENTRIES];
  logic                 mispredict_q;

  entry_t pushEntry, headEntry;
  logic   qFull, qEmpty;
  logic   resolveFire, mispredictNow, lookupFire, popNow;

  // Shift one new outcome into the low end of a history value; the oldest
  // bit falls off the top. Works unchanged for a single-bit history.
  function automatic logic [HIST_BITS-1:0] shiftIn(input logic [HIST_BITS-1:0] h,
                                                   input logic b);
    logic [HIST_BITS-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  assign lookup_counter = bpt_q[bhr_q];
  assign lookup_ready   = !qFull;
  assign mispredict     = mispredict_q;
  assign pushEntry      = '{hist: bhr_q, pred: lookup_counter[1]};

  // Decide what happens this cycle. A mispredicting resolve makes any
  // same-cycle lookup wrong-path, so it is neither pushed nor allowed to
  // shift the history; the repaired history comes from the resolved entry.
  always_comb begin
    resolveFire   = resolve_valid && !qEmpty;
    mispredictNow = resolveFire && (resolve_taken != headEntry.pred);
    lookupFire    = lookup_valid && lookup_ready && !mispredictNow;
    popNow        = resolveFire && !mispredictNow;
    bhr_d         = bhr_q;
    if (mispredictNow) begin
      bhr_d = shiftIn(headEntry.hist, resolve_taken);
    end else if (lookupFire) begin
      bhr_d = shiftIn(bhr_q, lookup_counter[1]);
    end
  end

  bpred_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (HIST_BITS + 1)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (lookupFire),
    .pop_i   (popNow),
    .flush_i (mispredictNow),
    .data_i  (pushEntry),
    .head_o  (headEntry),
    .count_o (pending_count),
    .full_o  (qFull),
    .empty_o (qEmpty)
  );

  // History register and the registered mispredict pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      bhr_q        <= '0;
      mispredict_q <= 1'b0;
    end else begin
      bhr_q        <= bhr_d;
      mispredict_q <= mispredictNow;
    end
  end

  // Pattern table training. The counter indexed by the resolved branch's
  // history is updated whether or not it mispredicted; a same-cycle lookup
  // still sees the old value because the read above is from the register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bpt_q[i] <= WNT;
    end else if (resolveFire) begin
      bpt_q[headEntry.hist] <= sat_next(bpt_q[headEntry.hist], resolve_taken);
    end
  end

endmodule

// File: tb/tb_bpred_train.sv
// -----------------------------------------------------------------------------
// tb_bpred_train
// Self-checking bench for bpred_train: a table of directed vectors, a few
// hand-written multi-cycle sequences, then random traffic compared against a
// behavioural model built from plain integers and a queue.
// -----------------------------------------------------------------------------
module tb_bpred_train;

  localparam int HB  = 2;
  localparam int QD  = 4;
  localparam int ENT = 4;

  logic       clock;
  logic       reset;
  logic       lookup_valid;
  logic       lookup_ready;
  logic [1:0] lookup_counter;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       mispredict;
  logic [2:0] pending_count;

  int checkCount = 0;
  int errCount   = 0;

  bpred_train #(
    .HIST_BITS (HB),
    .QDEPTH    (QD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .lookup_valid   (lookup_valid),
    .lookup_ready   (lookup_ready),
    .lookup_counter (lookup_counter),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .mispredict     (mispredict),
    .pending_count  (pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: plain integer history, counter array and a queue of
  // {history, predicted-direction} records.
  typedef struct {
    int hist;
    int pred;
  } ent_t;

  int   mBhr;
  int   mBpt [ENT];
  ent_t mQ [$];
  int   mMisp;

  task automatic modelReset();
    mBhr = 0;
    for (int i = 0; i < ENT; i++) mBpt[i] = 1;
    mQ.delete();
    mMisp = 0;
  endtask

  task automatic modelStep(input bit rst, input bit lv, input bit rv, input bit rt);
    int   pred;
    bit   acc;
    bit   mis;
    ent_t h;
    if (rst) begin
      modelReset();
      return;
    end
    pred = (mBpt[mBhr] >= 2) ? 1 : 0;
    acc  = lv && (mQ.size() < QD);
    mis  = 0;
    if (rv && mQ.size() > 0) begin
      h   = mQ[0];
      mis = (int'(rt) != h.pred);
      if (rt) mBpt[h.hist] = (mBpt[h.hist] == 3) ? 3 : mBpt[h.hist] + 1;
      else    mBpt[h.hist] = (mBpt[h.hist] == 0) ? 0 : mBpt[h.hist] - 1;
      if (mis) begin
        mQ.delete();
        mBhr = (h.hist * 2 + int'(rt)) % ENT;
      end else begin
        void'(mQ.pop_front());
      end
    end
    if (acc && !mis) begin
      mQ.push_back('{hist: mBhr, pred: pred});
      mBhr = (mBhr * 2 + pred) % ENT;
    end
    mMisp = mis;
  endtask

  task automatic checkField(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int eCtr, input int eReady,
                             input int eMisp, input int eCount);
    checkField({name, ".counter"},  int'(lookup_counter), eCtr);
    checkField({name, ".ready"},    int'(lookup_ready),   eReady);
    checkField({name, ".mispred"},  int'(mispredict),     eMisp);
    checkField({name, ".pending"},  int'(pending_count),  eCount);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // settle 1 time unit past the edge before anything is sampled.
  task automatic applyStimulus(input bit rst, input bit lv, input bit rv, input bit rt);
    reset         = rst;
    lookup_valid  = lv;
    resolve_valid = rv;
    resolve_taken = rt;
    @(posedge clock);
    modelStep(rst, lv, rv, rt);
    #1;
  endtask

  typedef struct {
    string name;
    bit    rst, lv, rv, rt;
    int    eCtr, eReady, eMisp, eCount;
  } vec_t;

  vec_t vecs [$];

  function automatic void addVec(input string n, input bit rst, input bit lv, input bit rv,
                                 input bit rt, input int c, input int r, input int m,
                                 input int p);
    vec_t v;
    v.name = n; v.rst = rst; v.lv = lv; v.rv = rv; v.rt = rt;
    v.eCtr = c; v.eReady = r; v.eMisp = m; v.eCount = p;
    vecs.push_back(v);
  endfunction

  initial begin
    reset         = 1'b1;
    lookup_valid  = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    modelReset();

    //      name            rst lv rv rt   ctr rdy mis cnt
    addVec("reset",         1,  0, 0, 0,   1,  1,  0,  0);
    addVec("idle",          0,  0, 0, 0,   1,  1,  0,  0);
    addVec("lk00",          0,  1, 0, 0,   1,  1,  0,  1);
    addVec("res00T_mis",    0,  0, 1, 1,   1,  1,  1,  0);
    addVec("pulse_end",     0,  0, 0, 0,   1,  1,  0,  0);
    addVec("lk01",          0,  1, 0, 0,   1,  1,  0,  1);
    addVec("res01T_mis",    0,  0, 1, 1,   1,  1,  1,  0);
    addVec("lk11a",         0,  1, 0, 0,   1,  1,  0,  1);
    addVec("res11T_mis",    0,  0, 1, 1,   2,  1,  1,  0);
    addVec("lk11b",         0,  1, 0, 0,   2,  1,  0,  1);
    addVec("res11T_ok",     0,  0, 1, 1,   3,  1,  0,  0);
    addVec("lk11c",         0,  1, 0, 0,   3,  1,  0,  1);
    addVec("lk_res_sat",    0,  1, 1, 1,   3,  1,  0,  1);
    addVec("res11NT_mis",   0,  0, 1, 0,   1,  1,  1,  0);
    addVec("lk10",          0,  1, 0, 0,   2,  1,  0,  1);
    addVec("res10T_mis",    0,  0, 1, 1,   2,  1,  1,  0);
    addVec("lk01_see11",    0,  1, 0, 0,   2,  1,  0,  1);
    addVec("res01T_ok",     0,  0, 1, 1,   2,  1,  0,  0);
    addVec("fill1",         0,  1, 0, 0,   2,  1,  0,  1);
    addVec("fill2",         0,  1, 0, 0,   2,  1,  0,  2);
    addVec("fill3",         0,  1, 0, 0,   2,  1,  0,  3);
    addVec("fill4",         0,  1, 0, 0,   2,  0,  0,  4);
    addVec("full_refuse",   0,  1, 1, 1,   3,  1,  0,  3);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].lv, vecs[i].rv, vecs[i].rt);
      checkOutput(vecs[i].name, vecs[i].eCtr, vecs[i].eReady, vecs[i].eMisp, vecs[i].eCount);
    end

    // Reset lands with three branches in flight and a mispredicting resolve
    // presented: everything returns to reset values and no pulse follows.
    applyStimulus(1, 1, 1, 0);
    checkOutput("midreset",       1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("midreset_idle",  1, 1, 0, 0);

    // Two branches in flight, then a mispredict together with a new lookup:
    // the lookup is dropped and history becomes {oldest.hist[0], actual}=11.
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_lk00",        1, 1, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("wp_fix",         1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_lk01",        1, 1, 0, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_lk10",        2, 1, 0, 2);
    applyStimulus(0, 1, 1, 1);
    checkOutput("wp_mis_lk",      1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wp_pulse_end",   1, 1, 0, 0);

    // Resolve with nothing in flight is ignored entirely.
    applyStimulus(0, 0, 1, 1);
    checkOutput("empty_resolve",  1, 1, 0, 0);

    // Random traffic against the behavioural model.
    for (int n = 0; n < 600; n++) begin
      bit rst, lv, rv, rt;
      rst = ($urandom_range(0, 59) == 0);
      lv  = ($urandom_range(0, 99) < 55);
      rv  = ($urandom_range(0, 99) < 40);
      rt  = $urandom_range(0, 1);
      applyStimulus(rst, lv, rv, rt);
      checkOutput("rand", mBpt[mBhr], (mQ.size() < QD) ? 1 : 0, mMisp, mQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bpred_train.md
Name: bpred_train

Overview:
Training and history side of the two-level branch predictor. It owns the global branch history register (BHR) and the 4-entry pattern table (BPT) of 2-bit saturating counters, and drives BPT[BHR] to the combinational prediction stage on each fetch-time lookup. It tracks in-flight predicted branches in a small FIFO and updates counters when execute resolves them. On a misprediction it repairs the speculative history and flushes all younger in-flight branches.

Parameters:
HIST_BITS, 2, BHR width; BPT has 2**HIST_BITS entries; legal range 1..8
QDEPTH, 4, maximum number of in-flight unresolved branches (power of 2, at least 2)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
lookup_valid  input  1  fetch has a conditional branch and requests a prediction
lookup_ready  output  1  lookup accepted this cycle if high; equals (count < QDEPTH), registered state only
lookup_counter  output  2  BPT[BHR], combinational read, feeds the prediction stage
resolve_valid  input  1  execute resolves the oldest in-flight branch
resolve_taken  input  1  actual outcome of that branch
mispredict  output  1  registered one-cycle pulse, cycle after a mispredicting resolve
pending_count  output  $clog2(QDEPTH+1)  in-flight entries

Behaviour:
- Reset values: BHR=0; every BPT entry=2'b01 (weakly not-taken); queue empty; pending_count=0; mispredict=0; lookup_ready=1.
- Reset is synchronous and applies mid-operation: all in-flight entries are discarded and no counter write occurs that cycle.
- Predicted direction is lookup_counter[1] (values 0-1 are not-taken, 2-3 are taken).
- Lookup accept (lookup_valid && lookup_ready):
  - Push entry {hist=BHR, pred=BPT[BHR][1]}.
  - BHR <= {BHR[HIST_BITS-2:0], pred}. When HIST_BITS=1, BHR <= pred.
- Resolve (resolve_valid with queue non-empty):
  - Pop the head entry.
  - BPT[head.hist] <= taken ? min(ctr+1, 3) : max(ctr-1, 0), read from the current table value.
- Resolve with an empty queue is ignored: no update, no pulse.
- Mispredict (resolve_taken != head.pred):
  - BHR <= {head.hist[HIST_BITS-2:0], resolve_taken}.
  - Queue cleared and pending_count <= 0.
  - mispredict=1 the next cycle only.
- Same-cycle lookup and correct resolve: both take effect, pending_count unchanged, BHR takes the lookup shift.
- Same-cycle lookup and mispredicting resolve: the lookup is wrong-path, so the push and its BHR shift are dropped and recovery wins.
- Same-cycle lookup reads the pre-write BPT value. There is no write-to-read bypass.
- lookup_ready does not depend on resolve_valid, so there is no combinational path from resolve to lookup.
- A full queue with a simultaneous pop still refuses the lookup.
- Queue pointers wrap modulo QDEPTH. Count arithmetic is sized to represent QDEPTH exactly.
- Latency:
  - Counter write is visible on lookup_counter the cycle after resolve.
  - BHR update is visible the cycle after accept or recovery.

Decomposition:
- Package bpred_pkg:
  - counter constants SNT=2'd0, WNT=2'd1, WT=2'd2, ST=2'd3;
  - queue entry typedef {hist, pred};
  - saturating update function sat_next(ctr, taken).
- One sub-module bpred_queue: synchronous FIFO with push, pop and flush (flush has priority over push), count and full outputs.
- BHR, BPT and control stay in bpred_train.

Test Plan:
1. Reset, then no activity -> lookup_counter=01, BHR=00, lookup_ready=1, mispredict=0, pending_count=0.
2. One lookup at BHR=00 (pred 0), then resolve_taken=1 -> BPT[00]=10, BHR=01, mispredict pulses for exactly one cycle, pending_count=0.
3. Train history 11: repeated lookup plus resolve_taken=1 -> BPT[11] goes 01→10→11 and stays at 11 on a further taken; one not-taken then gives 10.
4. Four lookups with no resolve -> pending_count=4 and lookup_ready=0. A fifth lookup_valid together with resolve (correct) is refused; pending_count=3 the next cycle.
5. Two lookups in flight, then a mispredicting resolve in the same cycle as a new lookup -> queue empty, BHR={oldest.hist[0], actual}, no push, mispredict=1.
6. Reset asserted with 3 entries in flight and a resolve pending -> all state at reset values, BPT untouched by that resolve.
